// File: rtl/mc_control_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mc_ctrl_pkg
// Description : Shared definitions for the multi-cycle MIPS control FSM:
//               opcodes, state enum, mux/ALU encodings, trap cause codes and
//               the Moore decode of the registered control word.
// Revision    : 1.0 - second-generation controller
// ============================================================================
package mc_ctrl_pkg;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_jal   = 6'b000011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_IMM_EX    = 4'd10,
        S_IMM_WB    = 4'd11,
        S_JAL_LINK  = 4'd12,
        S_TRAP      = 4'd13
    } state_t;

    localparam logic [1:0] c_regdst_rt  = 2'b00;
    localparam logic [1:0] c_regdst_rd  = 2'b01;
    localparam logic [1:0] c_regdst_ra  = 2'b10;
    localparam logic [1:0] c_wb_alu     = 2'b00;
    localparam logic [1:0] c_wb_mdr     = 2'b01;
    localparam logic [1:0] c_wb_pc      = 2'b10;
    localparam logic [1:0] c_pcsrc_seq  = 2'b00;
    localparam logic [1:0] c_pcsrc_br   = 2'b01;
    localparam logic [1:0] c_pcsrc_jmp  = 2'b10;
    localparam logic [1:0] c_aluop_add  = 2'b00;
    localparam logic [1:0] c_aluop_sub  = 2'b01;
    localparam logic [1:0] c_aluop_fn   = 2'b10;
    localparam logic [1:0] c_aluop_imm  = 2'b11;
    localparam logic [1:0] c_cause_none = 2'b00;
    localparam logic [1:0] c_cause_ill  = 2'b01;
    localparam logic [1:0] c_cause_bus  = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_control;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       alu_sel_a;
        logic       target_write;
        logic       cause_write;
        logic [1:0] reg_dst;
        logic [1:0] wb_sel;
        logic [1:0] alu_sel_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
    } ctrl_t;

    // Moore control word for a state. opc only matters in IMM_EX, where the
    // instruction register is already stable.
    function automatic ctrl_t ctrl_decode(state_t s, logic [5:0] opc, logic [1:0] trap_sel);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:     begin c.mem_read = 1'b1; c.alu_sel_b = 2'b01; end
            S_DECODE:    begin c.alu_sel_b = 2'b11; c.target_write = 1'b1; end
            S_MEM_ADDR:  begin c.alu_sel_a = 1'b1; c.alu_sel_b = 2'b10; end
            S_MEM_READ:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
            S_MEM_WB:    begin c.reg_write = 1'b1; c.wb_sel = c_wb_mdr; end
            S_MEM_WRITE: begin c.mem_write = 1'b1; c.iord = 1'b1; end
            S_EXECUTE:   begin c.alu_sel_a = 1'b1; c.alu_op = c_aluop_fn; end
            S_ALU_WB:    begin c.reg_write = 1'b1; c.reg_dst = c_regdst_rd; end
            S_BRANCH: begin
                c.alu_sel_a        = 1'b1;
                c.alu_op           = c_aluop_sub;
                c.pc_write_control = 1'b1;
                c.pc_src           = c_pcsrc_br;
            end
            S_JUMP:      begin c.pc_write = 1'b1; c.pc_src = c_pcsrc_jmp; end
            S_IMM_EX: begin
                c.alu_sel_a = 1'b1;
                c.alu_sel_b = 2'b10;
                c.alu_op    = (opc == c_op_andi || opc == c_op_ori) ? c_aluop_imm : c_aluop_add;
            end
            S_IMM_WB:    c.reg_write = 1'b1;
            S_JAL_LINK: begin
                c.reg_write = 1'b1;
                c.reg_dst   = c_regdst_ra;
                c.wb_sel    = c_wb_pc;
                c.pc_write  = 1'b1;
                c.pc_src    = c_pcsrc_jmp;
            end
            S_TRAP: begin
                c.pc_write    = 1'b1;
                c.pc_src      = trap_sel;
                c.cause_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_control_fsm_if.sv
`default_nettype none
// ============================================================================
// Interface   : mc_control_fsm_if
// Description : Controller <-> datapath bundle. master = controller (drives
//               enables/selects, cause, debug state), slave = datapath/memory
//               (drives opc, Zero, mem_ready).
// Revision    : 1.0 - second-generation controller
// ============================================================================
interface mc_control_fsm_if;
    logic [5:0] opc;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, PCWriteControl, IorD, MemRead, MemWrite;
    logic       IRWrite, RegWrite, ALUSelA, TargetWrite, CauseWrite;
    logic [1:0] RegDst, WbSel, ALUSelB, PCSrc, ALUOp, cause;
    logic [3:0] state_o;

    modport master (
        input  opc, Zero, mem_ready,
        output PCWrite, PCWriteControl, IorD, MemRead, MemWrite,
        output IRWrite, RegWrite, ALUSelA, TargetWrite, CauseWrite,
        output RegDst, WbSel, ALUSelB, PCSrc, ALUOp, cause, state_o
    );

    modport slave (
        output opc, Zero, mem_ready,
        input  PCWrite, PCWriteControl, IorD, MemRead, MemWrite,
        input  IRWrite, RegWrite, ALUSelA, TargetWrite, CauseWrite,
        input  RegDst, WbSel, ALUSelB, PCSrc, ALUOp, cause, state_o
    );
endinterface
`default_nettype wire

// File: rtl/mc_control_fsm_mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_timer
// Description : Saturating count of consecutive not-ready cycles of a memory
//               access. timeout pulses in the last permitted wait cycle.
// Ports       : clk, reset (sync, active-high), waiting (FSM is in a memory
//               state), mem_ready, timeout (combinational pulse)
// Revision    : 1.0 - second-generation controller
// ============================================================================
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic waiting,
    input  wire logic mem_ready,
    output logic      timeout
);
    localparam int              c_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [c_W-1:0] c_SAT = c_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT : 1);

    logic [c_W-1:0] r_count;

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            assign timeout = waiting & ~mem_ready & (r_count == c_W'(MEM_TIMEOUT - 1));
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

    // Any way out of the wait (ready, timeout, leaving the memory state)
    // restarts the count for the next access.
    always_ff @(posedge clk) begin
        if (reset || !waiting || mem_ready || timeout) begin
            r_count <= '0;
        end else if (r_count != c_SAT) begin
            r_count <= r_count + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm
// Description : Multi-cycle MIPS control FSM with variable-latency memory
//               handshake, bus-error timeout and precise trap path.
// Ports       : clk, reset (sync, active-high), bus (mc_control_fsm_if.master:
//               opc/Zero/mem_ready in; datapath enables, selects, cause and
//               state_o out)
// Revision    : 1.0 - second-generation controller
// ============================================================================
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter bit         ENABLE_JAL       = 1'b1,
    parameter bit         ENABLE_IMM_LOGIC = 1'b1,
    parameter int         MEM_TIMEOUT      = 16,
    parameter logic [1:0] TRAP_VECTOR_SEL  = 2'b11
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mc_control_fsm_if.master  bus
);
    state_t     r_state;
    state_t     w_next;
    ctrl_t      r_ctrl;
    logic [1:0] r_cause;
    logic [1:0] w_trap_cause;
    logic       w_waiting;
    logic       w_timeout;
    logic       w_in_fetch;
    logic       w_unused_zero;

    // Zero is consumed by the datapath's PCWriteControl gating, not here.
    assign w_unused_zero = bus.Zero;

    assign w_in_fetch = (r_state == S_FETCH);
    assign w_waiting  = w_in_fetch || (r_state == S_MEM_READ) || (r_state == S_MEM_WRITE);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .waiting   (w_waiting),
        .mem_ready (bus.mem_ready),
        .timeout   (w_timeout)
    );

    always_comb begin
        w_next       = r_state;
        w_trap_cause = c_cause_ill;
        case (r_state)
            S_FETCH: begin
                if (bus.mem_ready)  w_next = S_DECODE;
                else if (w_timeout) begin w_next = S_TRAP; w_trap_cause = c_cause_bus; end
            end
            S_DECODE: begin
                case (bus.opc)
                    c_op_lw, c_op_sw:     w_next = S_MEM_ADDR;
                    c_op_rtype:           w_next = S_EXECUTE;
                    c_op_beq:             w_next = S_BRANCH;
                    c_op_addi:            w_next = S_IMM_EX;
                    c_op_andi, c_op_ori:  w_next = ENABLE_IMM_LOGIC ? S_IMM_EX : S_TRAP;
                    c_op_j:               w_next = S_JUMP;
                    c_op_jal:             w_next = ENABLE_JAL ? S_JAL_LINK : S_TRAP;
                    default:              w_next = S_TRAP;
                endcase
            end
            S_MEM_ADDR: w_next = (bus.opc == c_op_lw) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: begin
                if (bus.mem_ready)  w_next = S_MEM_WB;
                else if (w_timeout) begin w_next = S_TRAP; w_trap_cause = c_cause_bus; end
            end
            S_MEM_WRITE: begin
                if (bus.mem_ready)  w_next = S_FETCH;
                else if (w_timeout) begin w_next = S_TRAP; w_trap_cause = c_cause_bus; end
            end
            S_EXECUTE: w_next = S_ALU_WB;
            S_IMM_EX:  w_next = S_IMM_WB;
            default:   w_next = S_FETCH;
        endcase
    end

    // The control word is decoded from the next state so every Moore output
    // comes straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ctrl  <= ctrl_decode(S_FETCH, bus.opc, TRAP_VECTOR_SEL);
            r_cause <= c_cause_none;
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_decode(w_next, bus.opc, TRAP_VECTOR_SEL);
            if (w_next == S_TRAP && r_state != S_TRAP) begin
                r_cause <= w_trap_cause;
            end
        end
    end

    // Instruction fetch commits (IR load and PC+4) only in the ready cycle.
    assign bus.IRWrite        = w_in_fetch & bus.mem_ready;
    assign bus.PCWrite        = r_ctrl.pc_write | (w_in_fetch & bus.mem_ready);
    assign bus.PCWriteControl = r_ctrl.pc_write_control;
    assign bus.IorD           = r_ctrl.iord;
    assign bus.MemRead        = r_ctrl.mem_read;
    assign bus.MemWrite       = r_ctrl.mem_write;
    assign bus.RegWrite       = r_ctrl.reg_write;
    assign bus.ALUSelA        = r_ctrl.alu_sel_a;
    assign bus.TargetWrite    = r_ctrl.target_write;
    assign bus.CauseWrite     = r_ctrl.cause_write;
    assign bus.RegDst         = r_ctrl.reg_dst;
    assign bus.WbSel          = r_ctrl.wb_sel;
    assign bus.ALUSelB        = r_ctrl.alu_sel_b;
    assign bus.PCSrc          = r_ctrl.pc_src;
    assign bus.ALUOp          = r_ctrl.alu_op;
    assign bus.cause          = r_cause;
    assign bus.state_o        = r_state;
endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control_fsm
// Description : Scoreboard bench for mc_control_fsm. Two instances: A with
//               JAL/ANDI/ORI enabled, B with both disabled; MEM_TIMEOUT=4.
// Revision    : 1.0
// ============================================================================
module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;

    localparam int T = 4;

    typedef struct packed {
        logic       memrd, memwr, iord, irw, pcw, pcwc, regw, causew, targw, alua;
        logic [1:0] pcsrc, regdst, wbsel, alub, aluop, cause;
    } ctl_t;

    typedef struct {
        int   cyc;
        ctl_t v;
        bit   chk_alu;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [5:0] opc;
    logic       zero, mem_ready;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         sel = 0;
    bit         mon_on = 1'b0;
    bit         m_jal, m_imm;
    logic [1:0] m_cause;
    exp_t       q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mc_control_fsm_if if_a ();
    mc_control_fsm_if if_b ();
    assign if_a.opc = opc;  assign if_a.Zero = zero;  assign if_a.mem_ready = mem_ready;
    assign if_b.opc = opc;  assign if_b.Zero = zero;  assign if_b.mem_ready = mem_ready;

    mc_control_fsm #(.ENABLE_JAL(1'b1), .ENABLE_IMM_LOGIC(1'b1), .MEM_TIMEOUT(T), .TRAP_VECTOR_SEL(2'b11))
        dut_a (.clk(clk), .reset(rst_a), .bus(if_a.master));
    mc_control_fsm #(.ENABLE_JAL(1'b0), .ENABLE_IMM_LOGIC(1'b0), .MEM_TIMEOUT(T), .TRAP_VECTOR_SEL(2'b11))
        dut_b (.clk(clk), .reset(rst_b), .bus(if_b.master));

    ctl_t act_a, act_b, act;
    assign act_a = {if_a.MemRead, if_a.MemWrite, if_a.IorD, if_a.IRWrite, if_a.PCWrite,
                    if_a.PCWriteControl, if_a.RegWrite, if_a.CauseWrite, if_a.TargetWrite,
                    if_a.ALUSelA, if_a.PCSrc, if_a.RegDst, if_a.WbSel, if_a.ALUSelB,
                    if_a.ALUOp, if_a.cause};
    assign act_b = {if_b.MemRead, if_b.MemWrite, if_b.IorD, if_b.IRWrite, if_b.PCWrite,
                    if_b.PCWriteControl, if_b.RegWrite, if_b.CauseWrite, if_b.TargetWrite,
                    if_b.ALUSelA, if_b.PCSrc, if_b.RegDst, if_b.WbSel, if_b.ALUSelB,
                    if_b.ALUOp, if_b.cause};
    assign act = (sel == 0) ? act_a : act_b;

    // Fields the specification leaves free in a cycle are not compared.
    function automatic ctl_t mask_of(ctl_t e, bit chk_alu);
        ctl_t m;
        m = '1;
        if (!(e.pcw || e.pcwc))      m.pcsrc = 2'b00;
        if (!e.regw)                 begin m.regdst = 2'b00; m.wbsel = 2'b00; end
        if (!chk_alu)                begin m.alua = 1'b0; m.alub = 2'b00; m.aluop = 2'b00; end
        if (!(e.memrd || e.memwr))   m.iord = 1'b0;
        return m;
    endfunction

    // Monitor: one expected control word per cycle while a phase is active.
    always @(negedge clk) begin
        if (mon_on) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL sb_empty cyc=%0d got=%h want=<entry>", cyc, act);
            end else begin
                exp_t e;
                ctl_t m;
                e = q.pop_front();
                m = mask_of(e.v, e.chk_alu);
                if (e.cyc != cyc || ((act ^ e.v) & m) != '0) begin
                    bad++;
                    $display("FAIL sb cyc=%0d/%0d got=%h want=%h mask=%h", cyc, e.cyc, act, e.v, m);
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic ctl_t blank();
        ctl_t c;
        c = '0;
        c.cause = m_cause;
        return c;
    endfunction

    function automatic bit legal(logic [5:0] o);
        return (o == c_op_lw || o == c_op_sw || o == c_op_rtype || o == c_op_beq ||
                o == c_op_addi || o == c_op_j ||
                (m_imm && (o == c_op_andi || o == c_op_ori)) || (m_jal && o == c_op_jal));
    endfunction

    // Reference model: builds the per-cycle expectation of one instruction
    // (fetch wait wf, memory wait wm) from the architectural rules, then
    // drives mem_ready along that same timeline.
    task automatic run_instr(logic [5:0] o, int wf, int wm);
        logic rv[$];
        int   t0;
        int   k;
        ctl_t c;
        t0 = cyc;
        k  = 0;
        for (int i = 0; i <= ((wf < T) ? wf : T - 1); i++) begin
            c = blank(); c.memrd = 1'b1; c.alub = 2'b01;
            c.irw = (i == wf); c.pcw = (i == wf);
            q.push_back('{t0 + k, c, 1'b1}); rv.push_back(i == wf); k++;
        end
        if (wf >= T) begin
            m_cause = c_cause_bus;
            c = blank(); c.pcw = 1'b1; c.pcsrc = 2'b11; c.causew = 1'b1;
            q.push_back('{t0 + k, c, 1'b0}); rv.push_back(1'b0); k++;
        end else begin
            c = blank(); c.targw = 1'b1;
            q.push_back('{t0 + k, c, 1'b0}); rv.push_back(1'b0); k++;
            if (!legal(o)) begin
                m_cause = c_cause_ill;
                c = blank(); c.pcw = 1'b1; c.pcsrc = 2'b11; c.causew = 1'b1;
                q.push_back('{t0 + k, c, 1'b0}); rv.push_back(1'b0); k++;
            end else if (o == c_op_lw || o == c_op_sw) begin
                c = blank(); c.alua = 1'b1; c.alub = 2'b10; c.aluop = 2'b00;
                q.push_back('{t0 + k, c, 1'b1}); rv.push_back(1'b0); k++;
                for (int i = 0; i <= ((wm < T) ? wm : T - 1); i++) begin
                    c = blank(); c.iord = 1'b1;
                    if (o == c_op_lw) c.memrd = 1'b1; else c.memwr = 1'b1;
                    q.push_back('{t0 + k, c, 1'b0}); rv.push_back(i == wm); k++;
                end
                if (wm >= T) begin
                    m_cause = c_cause_bus;
                    c = blank(); c.pcw = 1'b1; c.pcsrc = 2'b11; c.causew = 1'b1;
                    q.push_back('{t0 + k, c, 1'b0}); rv.push_back(1'b0); k++;
                end else if (o == c_op_lw) begin
                    c = blank(); c.regw = 1'b1; c.regdst = 2'b00; c.wbsel = 2'b01;
                    q.push_back('{t0 + k, c, 1'b0}); rv.push_back(1'b0); k++;
                end
            end else if (o == c_op_rtype) begin
                c = blank(); c.alua = 1'b1; c.alub = 2'b00; c.aluop = 2'b10;
                q.push_back('{t0 + k, c, 1'b1}); rv.push_back(1'b0); k++;
                c = blank(); c.regw = 1'b1; c.regdst = 2'b01; c.wbsel = 2'b00;
                q.push_back('{t0 + k, c, 1'b0}); rv.push_back(1'b0); k++;
            end else if (o == c_op_beq) begin
                c = blank(); c.alua = 1'b1; c.alub = 2'b00; c.aluop = 2'b01;
                c.pcwc = 1'b1; c.pcsrc = 2'b01;
                q.push_back('{t0 + k, c, 1'b1}); rv.push_back(1'b0); k++;
            end else if (o == c_op_j) begin
                c = blank(); c.pcw = 1'b1; c.pcsrc = 2'b10;
                q.push_back('{t0 + k, c, 1'b0}); rv.push_back(1'b0); k++;
            end else if (o == c_op_jal) begin
                c = blank(); c.regw = 1'b1; c.regdst = 2'b10; c.wbsel = 2'b10;
                c.pcw = 1'b1; c.pcsrc = 2'b10;
                q.push_back('{t0 + k, c, 1'b0}); rv.push_back(1'b0); k++;
            end else begin
                c = blank(); c.alua = 1'b1; c.alub = 2'b10;
                c.aluop = (o == c_op_addi) ? 2'b00 : 2'b11;
                q.push_back('{t0 + k, c, 1'b1}); rv.push_back(1'b0); k++;
                c = blank(); c.regw = 1'b1; c.regdst = 2'b00; c.wbsel = 2'b00;
                q.push_back('{t0 + k, c, 1'b0}); rv.push_back(1'b0); k++;
            end
        end
        opc = o;
        foreach (rv[i]) begin
            mem_ready = rv[i];
            zero      = 1'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_instr();
        logic [5:0] ops[10];
        int wf, wm;
        ops = '{c_op_lw, c_op_sw, c_op_rtype, c_op_beq, c_op_addi, c_op_andi,
                c_op_ori, c_op_j, c_op_jal, 6'($urandom)};
        wf = ($urandom_range(0, 9) == 0) ? $urandom_range(T, T + 1) : $urandom_range(0, T - 1);
        wm = ($urandom_range(0, 7) == 0) ? $urandom_range(T, T + 1) : $urandom_range(0, T - 1);
        run_instr(ops[$urandom_range(0, 9)], wf, wm);
    endtask

    task automatic check_reset(string tag);
        ctl_t a;
        logic [3:0] st;
        a  = act;
        st = (sel == 0) ? if_a.state_o : if_b.state_o;
        chk({tag, "_state"}, 32'(st), 32'(S_FETCH));
        chk({tag, "_we"}, 32'({a.pcw, a.irw, a.regw, a.memwr, a.causew, a.pcwc}), 32'd0);
        chk({tag, "_cause"}, 32'(a.cause), 32'd0);
        chk({tag, "_memrd"}, 32'(a.memrd), 32'd1);
    endtask

    task automatic start_phase(int s);
        mon_on    = 1'b0;
        sel       = s;
        rst_a     = 1'b1;
        rst_b     = 1'b1;
        mem_ready = 1'b0;
        opc       = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset(s == 0 ? "rstA" : "rstB");
        m_cause = c_cause_none;
        m_jal   = (s == 0);
        m_imm   = (s == 0);
        if (s == 0) rst_a = 1'b0; else rst_b = 1'b0;
        mon_on  = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        zero = 1'b0;
        start_phase(0);
        run_instr(c_op_lw, 3, 2);
        run_instr(c_op_jal, 0, 0);
        run_instr(6'b111111, 1, 0);
        run_instr(c_op_addi, 4, 0);      // bus error fetching the handler
        run_instr(c_op_sw, 0, 6);        // write timeout
        run_instr(c_op_sw, 2, 3);        // ready in the last wait cycle
        run_instr(c_op_lw, 0, 4);        // read timeout
        run_instr(c_op_andi, 0, 0);
        run_instr(c_op_ori, 1, 0);
        run_instr(c_op_rtype, 0, 0);
        run_instr(c_op_beq, 0, 0);
        run_instr(c_op_j, 0, 0);
        run_instr(c_op_lw, 3, 3);
        repeat (40) rand_instr();
        run_instr(6'b111111, 0, 0);      // leave cause nonzero
        mon_on = 1'b0;

        // Reset during a MEM_READ wait.
        opc = c_op_lw; mem_ready = 1'b1;
        @(posedge clk); #1; mem_ready = 1'b0;   // DECODE
        @(posedge clk); #1;                     // MEM_ADDR
        @(posedge clk); #1;                     // MEM_READ wait 0
        @(posedge clk); #1;                     // MEM_READ wait 1
        chk("midwait_iord", 32'({act.memrd, act.iord}), 32'b11);
        rst_a = 1'b1;
        @(posedge clk); #1;
        check_reset("midrst");
        rst_a = 1'b0;
        m_cause = c_cause_none;
        mon_on = 1'b1;
        run_instr(c_op_lw, 3, 1);
        run_instr(c_op_sw, 1, 1);
        mon_on = 1'b0;

        start_phase(1);
        run_instr(c_op_jal, 0, 0);
        run_instr(c_op_ori, 1, 0);
        run_instr(c_op_andi, 0, 0);
        run_instr(c_op_addi, 2, 0);
        run_instr(c_op_lw, 0, 1);
        run_instr(c_op_rtype, 0, 0);
        repeat (20) rand_instr();
        mon_on = 1'b0;

        chk("sb_drain", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
